// File: rtl/gf2m_mod_reducer.sv
// Sequential GF(2)[x] reducer: folds DIGIT high bits per clock of a 2*WIDTH-1 bit product modulo x^WIDTH + POLY_LOW.
// Optional macro GF2M_REDUCER_EARLY_EXIT_EN: finish as soon as the high half of the working register is clear.
module gf2m_mod_reducer #(
    parameter int                 WIDTH    = 128,
    parameter int                 DIGIT    = 8,
    parameter logic [WIDTH-1:0]   POLY_LOW = 128'h87
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2*WIDTH-2:0]   prod,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     res,
    output logic                 busy
);

    localparam int STEPS = WIDTH / DIGIT;
    localparam int CW    = $clog2(STEPS) + 1;
    localparam logic [2*WIDTH-1:0] FPOLY = {{(WIDTH-1){1'b0}}, 1'b1, POLY_LOW};

    if (!((DIGIT == 1) || (DIGIT == 2) || (DIGIT == 4) || (DIGIT == 8) ||
          (DIGIT == 16) || (DIGIT == 32)) || ((WIDTH % DIGIT) != 0)) begin : g_bad_digit
        $error("gf2m_mod_reducer: DIGIT must be one of 1,2,4,8,16,32 and divide WIDTH");
    end
    if ((POLY_LOW >> (WIDTH - DIGIT)) != '0) begin : g_bad_poly
        $error("gf2m_mod_reducer: degree of POLY_LOW must be below WIDTH-DIGIT");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                 state_r, state_nxt_s;
    logic [2*WIDTH-1:0]     r_r, r_nxt_s;
    logic [CW-1:0]          cnt_r, cnt_nxt_s;

    // One fold step: serial single-bit reduction over the DIGIT-wide window selected by cnt.
    // Because deg(POLY_LOW) < WIDTH-DIGIT, no fold disturbs another bit of the same window.
    function automatic logic [2*WIDTH-1:0] fold_step(input logic [2*WIDTH-1:0] r_in,
                                                     input logic [CW-1:0]      cnt_in);
        logic [2*WIDTH-1:0] acc;
        int                 top;
        acc = r_in;
        top = 2*WIDTH - 1 - int'(cnt_in) * DIGIT;
        for (int i = 2*WIDTH - 1; i >= WIDTH; i--) begin
            if ((i <= top) && (i > top - DIGIT) && acc[i]) begin
                acc = acc ^ (FPOLY << (i - WIDTH));
            end else begin
                acc = acc;
            end
        end
        return acc;
    endfunction

    // State, working register and step counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            r_r     <= '0;
            cnt_r   <= '0;
        end else begin
            state_r <= state_nxt_s;
            r_r     <= r_nxt_s;
            cnt_r   <= cnt_nxt_s;
        end
    end

    // Next-state and datapath selection.
    always_comb begin
        state_nxt_s = state_r;
        r_nxt_s     = r_r;
        cnt_nxt_s   = cnt_r;
        case (state_r)
            IDLE: begin
                if (in_valid && in_ready) begin
                    r_nxt_s     = {1'b0, prod};
                    cnt_nxt_s   = '0;
                    state_nxt_s = RUN;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            RUN: begin
`ifdef GF2M_REDUCER_EARLY_EXIT_EN
                if (r_r[2*WIDTH-1:WIDTH] == '0) begin
                    state_nxt_s = DONE;
                end else begin
                    r_nxt_s     = fold_step(r_r, cnt_r);
                    cnt_nxt_s   = cnt_r + CW'(1);
                    state_nxt_s = (cnt_r == CW'(STEPS - 1)) ? DONE : RUN;
                end
`else
                r_nxt_s     = fold_step(r_r, cnt_r);
                cnt_nxt_s   = cnt_r + CW'(1);
                state_nxt_s = (cnt_r == CW'(STEPS - 1)) ? DONE : RUN;
`endif
            end
            DONE: begin
                if (out_ready) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = DONE;
                end
            end
            default: begin
                state_nxt_s = IDLE;
                r_nxt_s     = '0;
                cnt_nxt_s   = '0;
            end
        endcase
    end

    // Outputs are registered from the next state so they align with state_r.
    always_ff @(posedge clk) begin
        if (rst) begin
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            res       <= '0;
        end else begin
            in_ready  <= (state_nxt_s == IDLE);
            out_valid <= (state_nxt_s == DONE);
            busy      <= (state_nxt_s == RUN) || (state_nxt_s == DONE);
            res       <= (state_nxt_s == DONE) ? r_nxt_s[WIDTH-1:0] : '0;
        end
    end

endmodule

// File: tb/tb_gf2m_mod_reducer.sv
// Scoreboard bench for gf2m_mod_reducer: expected residues queued at acceptance, compared when out_valid rises.
module tb_gf2m_mod_reducer;

    localparam int W     = 128;
    localparam int D     = 8;
    localparam int STEPS = W / D;
    localparam logic [2*W-1:0] FPOLY = {{(W-1){1'b0}}, 1'b1, 128'h87};

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [2*W-2:0]    prod;
    logic              out_valid;
    logic              out_ready;
    logic [W-1:0]      res;
    logic              busy;

    int                vec_cnt = 0;
    int                err_cnt = 0;
    logic [W-1:0]      exp_q[$];

    gf2m_mod_reducer #(.WIDTH(W), .DIGIT(D), .POLY_LOW(128'h87)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .prod(prod),
        .out_valid(out_valid), .out_ready(out_ready), .res(res), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Bit-serial reference reduction from the top coefficient downward.
    function automatic logic [W-1:0] ref_mod(input logic [2*W-2:0] p);
        logic [2*W-1:0] r;
        r = {1'b0, p};
        for (int i = 2*W - 1; i >= W; i--) begin
            if (r[i]) r = r ^ (FPOLY << (i - W));
        end
        return r[W-1:0];
    endfunction

    task automatic run_one(input logic [2*W-2:0] p, input logic [W-1:0] e_in,
                           input int hold, input logic [2*W-2:0] p2);
        int         waits;
        int         lat;
        int         exp_lat;
        logic [W-1:0] e;
        waits = 0;
        while (!in_ready && waits < 50) begin
            @(posedge clk); #1; waits++;
        end
        check_value("in_ready_wait", 256'(in_ready), 256'(1));
        prod = p;
        in_valid = 1'b1;
        exp_q.push_back(e_in);
        @(posedge clk); #1;
        in_valid = 1'b0;
        prod = '0;
        lat = 0;
        while (!out_valid && lat < 2*STEPS + 4) begin
            @(posedge clk); #1; lat++;
        end
`ifdef GF2M_REDUCER_EARLY_EXIT_EN
        exp_lat = (p[2*W-2:W] == '0) ? 1 : -1;
`else
        exp_lat = STEPS;
`endif
        if (exp_lat < 0) check_value("latency_bound", 256'((lat >= 1) && (lat <= STEPS) && out_valid), 256'(1));
        else             check_value("latency", 256'(lat), 256'(exp_lat));
        e = exp_q.pop_front();
        for (int h = 0; h < hold; h++) begin
            prod = p2;
            in_valid = 1'b1;
            check_value("hold_out_valid", 256'(out_valid), 256'(1));
            check_value("hold_in_ready", 256'(in_ready), 256'(0));
            check_value("hold_res", 256'(res), 256'(e));
            @(posedge clk); #1;
        end
        check_value("res", 256'(res), 256'(e));
        check_value("busy_done", 256'(busy), 256'(1));
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check_value("post_out_valid", 256'(out_valid), 256'(0));
        check_value("post_in_ready", 256'(in_ready), 256'(1));
        check_value("post_res_zero", 256'(res), 256'(0));
    endtask

    initial begin
        logic [255:0]   rnd;
        logic [2*W-2:0] p;
        logic [2*W-2:0] one128;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; prod = '0;
        one128 = '0;
        one128[128] = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_value("rst_in_ready", 256'(in_ready), 256'(1));
        check_value("rst_out_valid", 256'(out_valid), 256'(0));
        check_value("rst_res", 256'(res), 256'(0));
        check_value("rst_busy", 256'(busy), 256'(0));
        rst = 1'b0;

        // Reset in the middle of a run aborts it without output.
        prod = one128; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check_value("run_busy", 256'(busy), 256'(1));
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_value("abort_in_ready", 256'(in_ready), 256'(1));
        check_value("abort_out_valid", 256'(out_valid), 256'(0));
        check_value("abort_res", 256'(res), 256'(0));
        check_value("abort_busy", 256'(busy), 256'(0));

        run_one(one128, 128'h87, 0, '0);
        run_one(one128 << 1 | 255'd1, 128'h10F, 0, '0);
        run_one(one128 | 255'd1, 128'h86, 0, '0);
        run_one(255'hDEADBEEF, 128'hDEADBEEF, 0, '0);

        // Backpressure: new product offered during DONE must be ignored, then accepted.
        p = ~255'd0;
        run_one(p, ref_mod(p), 5, one128 | 255'd1);
        run_one(one128 | 255'd1, 128'h86, 0, '0);

        for (int n = 0; n < 1000; n++) begin
            for (int k = 0; k < 8; k++) rnd[k*32 +: 32] = $urandom;
            p = rnd[2*W-2:0];
            if ((n % 4) == 3) p[2*W-2:W] = '0;
            run_one(p, ref_mod(p), 0, '0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
